sseg_display_arbiter: RTL and testbench
=======================================

SSEG_DISPLAY_ARBITER -- requirements
Module: sseg_display_arbiter

Interface
REQ-001 Parameter REFRESH_N, default 18, scan counter width; each digit slot lasts 2^(REFRESH_N-2) cycles.
REQ-002 Parameter BLANK_CYC, default 64, cycles at the start of each digit slot with all anodes off (anti-ghosting); BLANK_CYC SHALL be less than 2^(REFRESH_N-2).
REQ-003 Parameter DWELL, default 50_000_000, minimum owner cycles before a contended handover.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high.
REQ-006 Port req, input, 2, bit0 = source A requests display, bit1 = source B.
REQ-007 Port val_a / val_b, input, 16 each, four hex digits; [15:12] is the leftmost digit (digit 3).
REQ-008 Port dp_a / dp_b, input, 4 each, active-high decimal point per digit.
REQ-009 Port lock, input, 1, when high the current owner is never pre-empted by dwell expiry.
REQ-010 Port grant, output, 2, one-hot owner (01 = A, 10 = B, 00 = none).
REQ-011 Port an, output, 4, active-low anode enables.
REQ-012 Port sseg, output, 8, active-low; [6:0] = segments g..a, [7] = decimal point.

Function
REQ-013 Scan counter q SHALL be a free-running REFRESH_N-bit counter that wraps from all-ones to 0; digit index = q[REFRESH_N-1:REFRESH_N-2]; slot offset = q[REFRESH_N-3:0].
REQ-014 A frame boundary SHALL be the cycle in which q == 0.
REQ-015 Owner FSM states SHALL be IDLE, OWN_A, OWN_B; transitions SHALL be evaluated only at a frame boundary.
REQ-016 IDLE: req[0] -> OWN_A; else req[1] -> OWN_B; else stay (A wins simultaneous requests from IDLE).
REQ-017 OWN_A: if req[0] is low -> OWN_B when req[1] is high, else IDLE; if req[0], req[1], lock low and dwell >= DWELL -> OWN_B; otherwise stay. OWN_B is symmetric, with A and B exchanged.
REQ-018 The dwell counter SHALL clear on every state change, increment each cycle in OWN_A/OWN_B, and saturate at DWELL.
REQ-019 At each frame boundary the snapshot (16-bit value, 4-bit dp) SHALL load from the source that is the owner after that boundary's transition; the snapshot SHALL hold for the whole frame.
REQ-020 In IDLE, or while slot offset < BLANK_CYC, an SHALL be 4'b1111 and sseg SHALL be 8'hFF.
REQ-021 Otherwise an SHALL drive low only the bit equal to the digit index; sseg[6:0] SHALL be the active-low hex 0-F glyph of the snapshot nibble; sseg[7] SHALL be the inverse of the snapshot dp bit.
REQ-022 an, sseg and grant SHALL be registered, lagging q and the FSM state by exactly one cycle.
REQ-023 req, lock or val changes mid-frame SHALL have no visible effect until the next frame boundary.

Reset
REQ-024 While reset is high at a clock edge: q = 0, state = IDLE, dwell = 0, snapshot = 0, grant = 00, an = 4'b1111, sseg = 8'hFF.
REQ-025 Reset asserted mid-frame or mid-dwell SHALL abort the frame and the dwell with no residual state.
REQ-026 The first frame boundary SHALL occur on the first cycle after reset deasserts (q == 0).

Structure
REQ-027 A shared package SHALL hold the owner-state encoding and the 16-entry hex-to-segment constant table.
REQ-028 Hex-to-segment decoding SHALL be a sub-module hex_to_sseg (4-bit hex in, 7-bit active-low segments out), instantiated once on the snapshot nibble.
REQ-029 Total RTL SHALL stay within 120-400 lines; no second clock domain.

Verification (bench uses REFRESH_N=6, BLANK_CYC=2, DWELL=100)
REQ-030 Reset, req=00 for 200 cycles -> grant=00, an=1111, sseg=FF throughout.
REQ-031 req=01, val_a=16'h12AF, dp_a=0100 -> after the next boundary, grant=01; slots show digit3 '1', digit2 '2' with sseg[7]=0, digit1 'A', digit0 'F'; an=1111 for the first 2 cycles of each slot.
REQ-032 req=11 together from IDLE -> OWN_A first; handover to B at the first boundary with dwell >= 100, then back to A after another 100+ cycles.
REQ-033 req=11, lock=1 for 500 cycles -> grant stays 01; lock=0 -> switches to 10 at the next eligible boundary.
REQ-034 Change val_a at mid-frame (q=20) -> displayed digits unchanged until q wraps to 0.
REQ-035 Assert reset at q=37 while OWN_B -> next cycle grant=00, an=1111, sseg=FF; after release, q restarts at 0.

Source files
------------

// File: rtl/sseg_display_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter: owner-state
// encoding, the hex glyph table and a grant encoder.
package sseg_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } owner_e;

    // Active-low glyphs, bit order g f e d c b a.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [1:0] grant_of(input owner_e s);
        case (s)
            ST_OWN_A: return 2'b01;
            ST_OWN_B: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sseg_display_arbiter_hex_to_sseg.sv
// Hex nibble to active-low seven-segment glyph (g..a), table driven.
module hex_to_sseg
    import sseg_display_arbiter_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/sseg_display_arbiter.sv
// Two-source multiplexed 4-digit seven-segment display with frame-aligned
// ownership arbitration, dwell-based handover and per-slot anti-ghost blanking.
module sseg_display_arbiter
    import sseg_display_arbiter_pkg::*;
#(
    parameter int REFRESH_N = 18,
    parameter int BLANK_CYC = 64,
    parameter int DWELL     = 50_000_000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] val_a,
    input  logic [15:0] val_b,
    input  logic [3:0]  dp_a,
    input  logic [3:0]  dp_b,
    input  logic        lock,
    output logic [1:0]  grant,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int SLOT_W  = REFRESH_N - 2;
    localparam int DWELL_W = $clog2(DWELL + 1);

    logic [REFRESH_N-1:0] q_q, q_d;
    owner_e               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [15:0]          snap_val_q, snap_val_d;
    logic [3:0]           snap_dp_q, snap_dp_d;
    logic [1:0]           grant_q, grant_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           sseg_q, sseg_d;

    logic                 boundary;
    logic                 dwell_done;
    logic [1:0]           digit;
    logic [SLOT_W-1:0]    offset;
    logic                 blank;
    logic [3:0]           nib [4];
    logic [3:0]           an_sel;
    logic [6:0]           glyph;

    assign q_d        = q_q + 1'b1;
    assign boundary   = (q_q == '0);
    assign dwell_done = (dwell_q >= DWELL_W'(DWELL));
    assign digit      = q_q[REFRESH_N-1 -: 2];
    assign offset     = q_q[SLOT_W-1:0];

    // Ownership only moves on frame boundaries so a frame never mixes sources.
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                ST_IDLE: begin
                    if (req[0])      state_d = ST_OWN_A;
                    else if (req[1]) state_d = ST_OWN_B;
                end
                ST_OWN_A: begin
                    if (!req[0])                         state_d = req[1] ? ST_OWN_B : ST_IDLE;
                    else if (req[1] && !lock && dwell_done) state_d = ST_OWN_B;
                end
                ST_OWN_B: begin
                    if (!req[1])                         state_d = req[0] ? ST_OWN_A : ST_IDLE;
                    else if (req[0] && !lock && dwell_done) state_d = ST_OWN_A;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q)
            dwell_d = '0;
        else if (state_q != ST_IDLE && !dwell_done)
            dwell_d = dwell_q + 1'b1;
    end

    // Snapshot follows the post-transition owner so the new owner's value
    // is what the new frame shows.
    always_comb begin
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        if (boundary) begin
            case (state_d)
                ST_OWN_A: begin snap_val_d = val_a; snap_dp_d = dp_a; end
                ST_OWN_B: begin snap_val_d = val_b; snap_dp_d = dp_b; end
                default:  begin snap_val_d = '0;    snap_dp_d = '0;   end
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign nib[gi]    = snap_val_q[gi*4 +: 4];
        assign an_sel[gi] = (digit != 2'(gi));
    end

    hex_to_sseg u_hex_to_sseg (
        .hex_i (nib[digit]),
        .seg_o (glyph)
    );

    assign blank   = (state_q == ST_IDLE) || (offset < SLOT_W'(BLANK_CYC));
    assign an_d    = blank ? 4'hF  : an_sel;
    assign sseg_d  = blank ? 8'hFF : {~snap_dp_q[digit], glyph};
    assign grant_d = grant_of(state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= '0;
            state_q    <= ST_IDLE;
            dwell_q    <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            grant_q    <= 2'b00;
            an_q       <= 4'hF;
            sseg_q     <= 8'hFF;
        end else begin
            q_q        <= q_d;
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            grant_q    <= grant_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
        end
    end

    assign grant = grant_q;
    assign an    = an_q;
    assign sseg  = sseg_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Scoreboard bench for sseg_display_arbiter: directed scenarios plus random
// traffic, expected outputs from a cycle-level behavioural model.
module tb_sseg_display_arbiter;

    localparam int RN    = 6;
    localparam int BLANK = 2;
    localparam int DW    = 100;
    localparam int FRAME = 1 << RN;
    localparam int SLOT  = 1 << (RN - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] val_a, val_b;
    logic [3:0]  dp_a, dp_b;
    logic        lock;
    logic [1:0]  grant;
    logic [3:0]  an;
    logic [7:0]  sseg;

    sseg_display_arbiter #(.REFRESH_N(RN), .BLANK_CYC(BLANK), .DWELL(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .val_a (val_a),
        .val_b (val_b),
        .dp_a  (dp_a),
        .dp_b  (dp_b),
        .lock  (lock),
        .grant (grant),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] g;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: cycles since reset release, owner (0 none, 1 A, 2 B),
    // first cycle of current ownership, and the frame's latched value.
    int          m_cyc   = 0;
    int          m_owner = 0;
    int          m_start = 0;
    logic [15:0] m_val   = '0;
    logic [3:0]  m_dp    = '0;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        string      lit;
        logic [6:0] on;
        on = '0;
        case (h)
            4'h0: lit = "abcdef";  4'h1: lit = "bc";      4'h2: lit = "abdeg";  4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";    4'h5: lit = "acdfg";   4'h6: lit = "acdefg"; 4'h7: lit = "abc";
            4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";  4'hA: lit = "abcefg"; 4'hB: lit = "cdefg";
            4'hC: lit = "adef";    4'hD: lit = "bcdeg";   4'hE: lit = "adefg";  default: lit = "aefg";
        endcase
        for (int i = 0; i < lit.len(); i++) on[int'(lit[i]) - 97] = 1'b1;
        return ~on;
    endfunction

    // Predict the outputs produced by the coming rising edge, then advance the model.
    task automatic model_step();
        exp_t e;
        int   q, off, d, nxt;
        logic mine, theirs;
        q   = m_cyc % FRAME;
        off = q % SLOT;
        d   = q / SLOT;
        if (reset) begin
            e = '{2'b00, 4'hF, 8'hFF};
        end else begin
            e.g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            if (m_owner == 0 || off < BLANK) begin
                e.an  = 4'hF;
                e.seg = 8'hFF;
            end else begin
                e.an  = ~(4'(1) << d);
                e.seg = {~m_dp[d], glyph(m_val[4*d +: 4])};
            end
        end
        sb_q.push_back(e);

        if (reset) begin
            m_cyc = 0; m_owner = 0; m_start = 0; m_val = '0; m_dp = '0;
        end else begin
            if (q == 0) begin
                if (m_owner == 0) begin
                    nxt = req[0] ? 1 : (req[1] ? 2 : 0);
                end else begin
                    mine   = req[m_owner - 1];
                    theirs = req[2 - m_owner];
                    if (!mine)
                        nxt = theirs ? 3 - m_owner : 0;
                    else if (theirs && !lock && (m_cyc - m_start) >= DW)
                        nxt = 3 - m_owner;
                    else
                        nxt = m_owner;
                end
                if (nxt != m_owner) m_start = m_cyc + 1;
                m_owner = nxt;
                if (nxt == 1)      begin m_val = val_a; m_dp = dp_a; end
                else if (nxt == 2) begin m_val = val_b; m_dp = dp_b; end
            end
            m_cyc++;
        end
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic step_to_q(input int target);
        while (m_cyc % FRAME != target) step();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] code, input int limit, input string name);
        int n;
        n = 0;
        while (an !== code && n < limit) begin step(); n++; end
        total++;
        if (an !== code) begin
            bad++;
            $display("FAIL %s: timeout an=%b want %b", name, an, code);
        end
    endtask

    task automatic wait_grant(input logic [1:0] code, input int limit, input string name);
        int n;
        n = 0;
        while (grant !== code && n < limit) begin step(); n++; end
        total++;
        if (grant !== code) begin
            bad++;
            $display("FAIL %s: timeout grant=%b want %b", name, grant, code);
        end
    endtask

    // Monitor: every cycle's outputs against the queued prediction.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                total++;
                if ({grant, an, sseg} !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got grant=%b an=%b sseg=%h want grant=%b an=%b sseg=%h",
                             $time, grant, an, sseg, e.g, e.an, e.seg);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req = 2'b00; lock = 1'b0;
        val_a = '0; val_b = '0; dp_a = '0; dp_b = '0;
        @(negedge clk);
        run(3);
        check("reset_grant", {6'b0, grant}, 8'h00);
        check("reset_an",    {4'b0, an},    8'h0F);
        check("reset_sseg",  sseg,          8'hFF);

        reset = 1'b0;
        run(200);
        check("idle_grant", {6'b0, grant}, 8'h00);
        check("idle_an",    {4'b0, an},    8'h0F);
        $display("[idle] 200 cycles with no request");

        req = 2'b01; val_a = 16'h12AF; dp_a = 4'b0100;
        wait_an(4'b0111, 200, "wait_digit3");
        check("digit3_1", sseg, 8'hF9);
        check("grant_a", {6'b0, grant}, 8'h01);
        wait_an(4'b1110, 100, "wait_digit0");
        check("digit0_F", sseg, 8'h8E);
        wait_an(4'b1101, 100, "wait_digit1");
        check("digit1_A", sseg, 8'h88);
        wait_an(4'b1011, 100, "wait_digit2");
        check("digit2_2dp", sseg, 8'h24);
        $display("[own_a] showing 12AF with dp on digit 2");

        step_to_q(20);
        val_a = 16'h9876; dp_a = 4'b0000;
        wait_an(4'b0111, 100, "wait_old_digit3");
        check("midframe_hold", sseg, 8'hF9);
        wait_an(4'b1110, 100, "wait_new_digit0");
        check("newframe_digit0", sseg, 8'h82);
        wait_an(4'b0111, 100, "wait_new_digit3");
        check("newframe_digit3", sseg, 8'h90);
        $display("[midframe] value change deferred to next frame");

        reset = 1'b1; val_b = 16'hC0DE; dp_b = 4'b1001;
        run(2);
        reset = 1'b0; req = 2'b11;
        run(10);
        check("contend_first_a", {6'b0, grant}, 8'h01);
        wait_grant(2'b10, 300, "handover_to_b");
        wait_grant(2'b01, 300, "handover_to_a");
        $display("[contend] A -> B -> A handovers after dwell");

        lock = 1'b1;
        run(500);
        check("lock_holds_a", {6'b0, grant}, 8'h01);
        lock = 1'b0;
        wait_grant(2'b10, 200, "unlock_to_b");
        $display("[lock] owner held while locked, released afterwards");

        step_to_q(37);
        check("pre_reset_b", {6'b0, grant}, 8'h02);
        reset = 1'b1;
        step();
        check("midreset_grant", {6'b0, grant}, 8'h00);
        check("midreset_an",    {4'b0, an},    8'h0F);
        check("midreset_sseg",  sseg,          8'hFF);
        reset = 1'b0;
        wait_grant(2'b01, 10, "after_reset_a");
        $display("[reset] mid-frame reset cleared ownership");

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) lock = ~lock;
            if ($urandom_range(0, 19) == 0) begin val_a = 16'($urandom); dp_a = 4'($urandom); end
            if ($urandom_range(0, 19) == 0) begin val_b = 16'($urandom); dp_b = 4'($urandom); end
            if ($urandom_range(0, 799) == 0) reset = 1'b1;
            else if (reset && $urandom_range(0, 1) == 0) reset = 1'b0;
            step();
            if (i % 1000 == 999) $display("[random] %0d cycles issued", i + 1);
        end
        reset = 1'b0;
        run(3);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
